// File: rtl/avalon_ram_slave_if.sv
// rtl/avalon_ram_slave_if.sv - Avalon-MM bus bundle between CPU master and RAM slave
interface avalon_ram_slave_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_ram_slave.sv
// rtl/avalon_ram_slave.sv - Avalon-MM RAM slave with wait states and backdoor preload port
// Optional byte-lane write masking: define RAM_BYTEENABLE_EN.
module avalon_ram_slave #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic                clk,
    input  logic                RAM_Reset,
    avalon_ram_slave_if.slave   bus,
    input  logic                inst_input,
    input  logic [ADDR_W+1:0]   inst_addr,
    input  logic [31:0]         instruction
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic [31:0]        readdata_q;
    logic               waitreq;
    logic [31:0]        mem [DEPTH];

    logic [31:0]        offset;
    logic               in_window;
    logic [ADDR_W-1:0]  word_idx;
    logic               bus_req;
    logic               is_read;
    logic               commit;
    logic               entering_ack;
    logic               unused_bits;

    assign offset    = bus.address - BASE_ADDR;
    assign in_window = (offset >> (ADDR_W + 2)) == 32'd0;
    assign word_idx  = offset[ADDR_W+1:2];
    assign bus_req   = bus.read | bus.write;
    // A simultaneous read+write is a write; readdata is left untouched.
    assign is_read   = bus.read & ~bus.write;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        waitreq    = 1'b0;
        case (state)
            IDLE: begin
                waitreq = bus_req;
                if (bus_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACK;
                    end else begin
                        cnt_next   = WAIT_INIT;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                waitreq = 1'b1;
                if (!bus_req) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RAM_Reset) begin
        if (!RAM_Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign entering_ack = (state_next == ACK) && (state != ACK);

    always_ff @(posedge clk or negedge RAM_Reset) begin
        if (!RAM_Reset) begin
            readdata_q <= 32'd0;
        end else if (entering_ack && is_read) begin
            readdata_q <= in_window ? mem[word_idx] : 32'd0;
        end
    end

    // Writes land on the edge leaving ACK; reset forces IDLE so an aborted write never commits.
    assign commit = (state == ACK) && bus.write && in_window;

    // Memory has no reset so a preloaded program survives a CPU reset.
    always_ff @(posedge clk) begin
        if (commit) begin
`ifdef RAM_BYTEENABLE_EN
            for (int n = 0; n < 4; n++) begin
                if (bus.byteenable[n]) begin
                    mem[word_idx][8*n +: 8] <= bus.writedata[8*n +: 8];
                end
            end
`else
            mem[word_idx] <= bus.writedata;
`endif
        end
        // Later assignment wins, so the backdoor overrides a same-edge bus write.
        if (inst_input) begin
            mem[inst_addr[ADDR_W+1:2]] <= instruction;
        end
    end

`ifdef RAM_BYTEENABLE_EN
    assign unused_bits = ^{offset[1:0], inst_addr[1:0]};
`else
    assign unused_bits = ^{offset[1:0], inst_addr[1:0], bus.byteenable};
`endif

    assign bus.waitrequest = waitreq;
    assign bus.readdata    = readdata_q;
endmodule

// File: tb/tb_avalon_ram_slave.sv
// tb/tb_avalon_ram_slave.sv - directed table-driven bench for avalon_ram_slave
module tb_avalon_ram_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        bd_en, bd_en0;
    logic [9:0]  bd_addr, bd_addr0;
    logic [31:0] bd_data, bd_data0;

    avalon_ram_slave_if bus ();
    avalon_ram_slave_if bus0 ();

    avalon_ram_slave #(.ADDR_W(8), .WAIT_CYCLES(2), .BASE_ADDR(32'hBFC00000)) dut (
        .clk(clk), .RAM_Reset(rst_n), .bus(bus),
        .inst_input(bd_en), .inst_addr(bd_addr), .instruction(bd_data)
    );

    avalon_ram_slave #(.ADDR_W(8), .WAIT_CYCLES(0), .BASE_ADDR(32'hBFC00000)) dut0 (
        .clk(clk), .RAM_Reset(rst_n), .bus(bus0),
        .inst_input(bd_en0), .inst_addr(bd_addr0), .instruction(bd_data0)
    );

`ifdef RAM_BYTEENABLE_EN
    localparam logic [31:0] EXP_PARTIAL = 32'h1122BEEF;
    localparam logic [31:0] EXP_BE0     = 32'h10000003;
`else
    localparam logic [31:0] EXP_PARTIAL = 32'hDEADBEEF;
    localparam logic [31:0] EXP_BE0     = 32'h0BADF00D;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_bus(input bit sel, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (sel) begin
            bus0.read = rd; bus0.write = wr; bus0.address = addr;
            bus0.writedata = data; bus0.byteenable = be;
        end else begin
            bus.read = rd; bus.write = wr; bus.address = addr;
            bus.writedata = data; bus.byteenable = be;
        end
    endtask

    task automatic backdoor(input bit sel, input logic [9:0] a, input logic [31:0] d);
        if (sel) begin bd_en0 = 1'b1; bd_addr0 = a; bd_data0 = d; end
        else     begin bd_en  = 1'b1; bd_addr  = a; bd_data  = d; end
        @(posedge clk); #1;
        bd_en = 1'b0; bd_en0 = 1'b0;
    endtask

    task automatic xfer(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                        output int stalls, output logic [31:0] rdata);
        logic wreq;
        bit   done;
        set_bus(sel, rd, wr, addr, data, be);
        #1;
        stalls = 0;
        done   = 1'b0;
        rdata  = 32'hx;
        for (int i = 0; i < 40; i++) begin
            wreq = sel ? bus0.waitrequest : bus.waitrequest;
            if (!wreq) begin
                rdata = sel ? bus0.readdata : bus.readdata;
                done  = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!done) begin
            failures++;
            $display("FAIL xfer_timeout actual=stuck required=ack addr=%h", addr);
        end
        @(posedge clk); #1;
        set_bus(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    vec_t        vecs [17];
    int          st;
    logic [31:0] rd;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'hBFC00004, 32'h0,         4'hF, 1'b1, 32'h24020010};
        vecs[1]  = '{1'b1, 1'b0, 32'hBFC00000, 32'h0,         4'hF, 1'b1, 32'h10000000};
        vecs[2]  = '{1'b1, 1'b0, 32'hBFC00007, 32'h0,         4'hF, 1'b1, 32'h24020010};
        vecs[3]  = '{1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF,  4'h3, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'hBFC00010, 32'h0,         4'hF, 1'b1, EXP_PARTIAL};
        vecs[5]  = '{1'b1, 1'b0, 32'h00000000, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h00000000, 32'hCAFEF00D,  4'hF, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'hBFC00000, 32'h0,         4'hF, 1'b1, 32'h10000000};
        vecs[8]  = '{1'b1, 1'b0, 32'hBFC003FC, 32'h0,         4'hF, 1'b1, 32'h100000FF};
        vecs[9]  = '{1'b1, 1'b0, 32'hBFC00400, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'hBFC00400, 32'hCAFEF00D,  4'hF, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'hBFC00000, 32'h0,         4'hF, 1'b1, 32'h10000000};
        vecs[12] = '{1'b0, 1'b1, 32'hBFC0000C, 32'h0BADF00D,  4'h0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'hBFC0000C, 32'h0,         4'hF, 1'b1, EXP_BE0};
        vecs[14] = '{1'b1, 1'b1, 32'hBFC00008, 32'h77777777,  4'hF, 1'b1, EXP_BE0};
        vecs[15] = '{1'b1, 1'b0, 32'hBFC00008, 32'h0,         4'hF, 1'b1, 32'h77777777};
        vecs[16] = '{1'b1, 1'b0, 32'hBFC00004, 32'h0,         4'hF, 1'b1, 32'h24020010};

        rst_n = 1'b0;
        bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        bd_en0 = 1'b0; bd_addr0 = '0; bd_data0 = '0;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_bus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_waitreq_idle", {31'b0, bus.waitrequest}, 32'h0);
        bus.read = 1'b1; #1;
        check("reset_waitreq_follows_read", {31'b0, bus.waitrequest}, 32'h1);
        bus.read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            backdoor(1'b0, 10'(i * 4), 32'h10000000 + 32'(i));
        end
        backdoor(1'b0, 10'h3FC, 32'h100000FF);
        backdoor(1'b0, 10'h004, 32'h24020010);
        backdoor(1'b0, 10'h010, 32'h11223344);

        for (int i = 0; i < 17; i++) begin
            xfer(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, st, rd);
            check($sformatf("vec%0d_stalls", i), 32'(st), 32'd3);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_readdata", i), rd, vecs[i].exp_rd);
        end

        // Reset while a write sits in WAIT: control resets, memory untouched.
        set_bus(1'b0, 1'b0, 1'b1, 32'hBFC00018, 32'h66666666, 4'hF);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("rst_mid_readdata", bus.readdata, 32'h0);
        check("rst_mid_waitreq_write", {31'b0, bus.waitrequest}, 32'h1);
        @(posedge clk); #1;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        check("rst_mid_state_idle", {31'b0, bus.waitrequest}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC00018, 32'h0, 4'hF, st, rd);
        check("rst_word6_unchanged", rd, 32'h10000006);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, st, rd);
        check("rst_program_kept", rd, 32'h24020010);

        // Master drops a write during WAIT.
        set_bus(1'b0, 1'b0, 1'b1, 32'hBFC0001C, 32'h99999999, 4'hF);
        @(posedge clk); #1;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        check("drop_waitreq_in_wait", {31'b0, bus.waitrequest}, 32'h1);
        @(posedge clk); #1;
        check("drop_back_to_idle", {31'b0, bus.waitrequest}, 32'h0);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0001C, 32'h0, 4'hF, st, rd);
        check("drop_word7_unchanged", rd, 32'h10000007);

        // Same-edge backdoor and bus write to word 5.
        set_bus(1'b0, 1'b0, 1'b1, 32'hBFC00014, 32'h55555555, 4'hF);
        #1;
        for (int i = 0; i < 10 && bus.waitrequest; i++) begin
            @(posedge clk); #1;
        end
        check("collide_reached_ack", {31'b0, bus.waitrequest}, 32'h0);
        bd_en = 1'b1; bd_addr = 10'h014; bd_data = 32'hAAAAAAAA;
        @(posedge clk); #1;
        bd_en = 1'b0;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC00014, 32'h0, 4'hF, st, rd);
        check("collide_backdoor_wins", rd, 32'hAAAAAAAA);

        // Zero wait states, back-to-back reads.
        backdoor(1'b1, 10'h004, 32'hA1A1A1A1);
        backdoor(1'b1, 10'h008, 32'hB2B2B2B2);
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, st, rd);
        check("ws0_first_stalls", 32'(st), 32'd1);
        check("ws0_first_data", rd, 32'hA1A1A1A1);
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC00008, 32'h0, 4'hF, st, rd);
        check("ws0_second_stalls", 32'(st), 32'd1);
        check("ws0_second_data", rd, 32'hB2B2B2B2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/avalon_ram_slave.md
# avalon_ram_slave

Synchronous Avalon-MM slave memory that sits directly downstream of `top_level_cpu`'s bus master and serves both instruction fetches and data accesses. It inserts a programmable number of wait states through `waitrequest`, applies byte-lane write masking, and exposes a backdoor port so benches can preload a program before releasing the CPU. It is the synthesizable, cycle-accurate memory used by all CPU testbenches.

## Interface
- `ADDR_W`, default 8, word-index width; depth is 2^ADDR_W words.
- `WAIT_CYCLES`, default 2, extra stall cycles per transfer (0..15).
- `BASE_ADDR`, default 32'hBFC00000, byte address of word 0.
- `clk`  in  1  system clock, rising edge.
- `RAM_Reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  byte address from master; bits [1:0] ignored.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `byteenable`  in  4  lane mask; bit n selects bits [8n+7:8n].
- `waitrequest`  out  1  stall; master holds request while high.
- `readdata`  out  32  read data, valid in the cycle `waitrequest` falls with `read` high.
- `inst_input`  in  1  backdoor write enable.
- `inst_addr`  in  ADDR_W+2  backdoor byte offset from `BASE_ADDR`.
- `instruction`  in  32  backdoor write data (full word).

## Operation
- Word index = (`address` − `BASE_ADDR`)[ADDR_W+1:2]. Out-of-window address (offset ≥ 4·2^ADDR_W): reads return 32'h0, writes dropped; handshake still completes normally.
- FSM states: IDLE, WAIT, ACK.
- IDLE: `waitrequest` = `read`|`write` (combinational). On request: if WAIT_CYCLES=0 go to ACK, else load counter with WAIT_CYCLES−1 and go to WAIT.
- WAIT: `waitrequest`=1; decrement counter; at 0 go to ACK.
- ACK: `waitrequest`=0. Read: `readdata` was registered on the edge entering ACK. Write commits on the edge leaving ACK. Next state IDLE.
- `read` and `write` both high: treated as write; `readdata` holds its previous value.
- Request dropped by master before ACK: FSM returns to IDLE next edge, no memory update.
- Backdoor: when `inst_input`=1, word `inst_addr[ADDR_W+1:2]` ← `instruction` at the rising edge, independent of FSM state. Same-edge collision with bus write to same word: backdoor wins.
- Reset affects control only: state→IDLE, counter→0, `readdata`→0. Memory contents are preserved across reset. Reset mid-transfer aborts it with no write commit.

## Timing
- Read latency from request seen in IDLE to `waitrequest` low: WAIT_CYCLES+1 cycles; `readdata` valid in that cycle.
- Minimum one stall cycle per transfer even with WAIT_CYCLES=0.
- Back-to-back requests: one IDLE cycle between transfers (ACK→IDLE→…), i.e. throughput one transfer per WAIT_CYCLES+2 cycles.
- Outputs during reset: `waitrequest` = `read`|`write` (state is IDLE), `readdata`=0.
- Backdoor writes visible to a bus read whose ACK-entry edge is at least one cycle later.

## Configuration
- `RAM_BYTEENABLE_EN` defined: write merges only lanes with `byteenable` bit set; `byteenable`=4'b0000 writes nothing.
- Not defined: `byteenable` ignored; every bus write stores the full 32-bit word.

## Test plan
- Backdoor load 32'h24020010 at `inst_addr`=8'h04, then read 32'hBFC00004 with WAIT_CYCLES=2 → `waitrequest` high 3 cycles, then low with `readdata`=32'h24020010.
- Write 32'hDEADBEEF to 32'hBFC00010, byteenable 4'b0011 (macro on) over prior 32'h11223344 → read returns 32'h1122BEEF; macro off → 32'hDEADBEEF.
- Read 32'h00000000 (out of window) → handshake completes, `readdata`=32'h0; write there leaves all words unchanged.
- Assert `RAM_Reset`=0 in WAIT of a write → `readdata`=0, state IDLE, target word unchanged; after release, previously loaded program still reads back correctly.
- WAIT_CYCLES=0, two back-to-back reads of 32'hBFC00004 and 32'hBFC00008 → each `waitrequest` high exactly 1 cycle, one IDLE gap between.
- Same-edge backdoor write 32'hAAAAAAAA and bus write 32'h55555555 to word 5 → read returns 32'hAAAAAAAA.
